eql_irq_peer: RTL and testbench
===============================

Name: eql_irq_peer

Overview:
- Peripheral-side counterpart of the interrupt-handshake controller.
- Drives the controller's `eql` and `cont_eql` inputs and observes its `cc_mux`, `uscite`, `enable_count` and `ackout` outputs.
- Turns an external service request into an `eql` request/hold/release handshake.
- Keeps the event counter whose terminal compare is reported on `cont_eql`.

Parameters:
- CNT_W, 4, width of event counter.
- CMP_VAL, 9, terminal count; `cont_eql` asserted when count equals this value (must be < 2^CNT_W).
- HOLD_CYC, 2, cycles `eql` stays high after acknowledge is seen (≥1).
- TIMEOUT, 8, max cycles in REQ waiting for acknowledge before abort (≥1).

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- req_in, in, 1, external service request, level; sampled only in IDLE.
- cc_mux, in, 2, controller mux code; 2'b11 = acknowledge-in.
- uscite, in, 2, controller output code; 2'b00 = acknowledging, 2'b01 normal, 2'b11 interrupt.
- enable_count, in, 1, counter increment enable from controller.
- ackout, in, 1, controller ack; used only for the `ack_seen` status.
- eql, out, 1, request/equality line to controller.
- cont_eql, out, 1, counter-at-terminal flag.
- count, out, CNT_W, current event count.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse on handshake completion.
- err, out, 1, one-cycle pulse on acknowledge timeout.
- ack_seen, out, 1, sticky; set when `ackout`=1 while busy, cleared in IDLE.

Behaviour:
- Reset:
  - Applies on the rising edge with `reset`=1 and overrides everything, including mid-handshake.
  - state=IDLE; eql, count, done, err, ack_seen, busy all 0. `cont_eql`=0 (CMP_VAL≠0).
- FSM: IDLE, REQ, HOLD, RELEASE, COOL. All outputs are registered except `cont_eql` and `busy`, which decode registered state/count with no extra latency.
- IDLE:
  - eql=0.
  - `req_in`=1 → REQ, with eql=1 from the next cycle; timeout counter loads TIMEOUT-1.
- REQ:
  - eql=1.
  - If `cc_mux`==2'b11 → HOLD; hold counter loads HOLD_CYC-1.
  - Else if timeout counter==0 → IDLE, eql←0, err pulse.
  - Else decrement the timeout counter.
  - Acknowledge takes priority over timeout in the same cycle.
- HOLD:
  - eql=1; decrement the hold counter.
  - When it is 0 → RELEASE with eql←0.
  - Total eql-high cycles after the ack-sampling edge = HOLD_CYC.
- RELEASE:
  - eql=0.
  - Wait for `uscite`≠2'b00, which marks the controller leaving acknowledge.
  - On that cycle → COOL, done pulse, count cleared to 0.
  - No timeout in RELEASE.
- COOL:
  - eql=0 for exactly one cycle → IDLE.
  - `req_in` is ignored during COOL.
- Counter:
  - Increments when `enable_count`=1 and count≠CMP_VAL; saturates at CMP_VAL and never wraps.
  - Clear (entry to COOL) beats increment in the same cycle.
  - `cont_eql` = (count==CMP_VAL).
- `ack_seen`: set on any cycle with `ackout`=1 and busy=1; cleared on entry to IDLE.
- `req_in` held high continuously produces back-to-back handshakes separated by COOL + IDLE: eql low for at least 2 cycles.

Test Plan:
- Reset mid-HOLD (HOLD_CYC=2): assert reset one cycle after ack → next edge eql=0, count=0, busy=0; state IDLE, and req_in=0 keeps eql low.
- Normal handshake: req_in pulse at cycle 0 → eql=1 at cycle 1; cc_mux=11 at cycle 3 → eql high through cycle 5, low at 6; uscite=01 at cycle 8 → done=1 at cycle 9, busy=0 at cycle 10.
- Timeout (TIMEOUT=8): req_in=1, cc_mux held 01 → eql high exactly 8 cycles, err pulse once, busy=0 the following cycle.
- Ack and timeout in the same cycle: cc_mux=11 on the last timeout cycle → HOLD entered, err stays 0.
- Counter saturation: enable_count=1 for 15 cycles → count stops at 9, cont_eql=1 from the cycle count reaches 9; a subsequent done → count=0, cont_eql=0.
- Clear vs increment: enable_count=1 on the RELEASE→COOL cycle with count=5 → count=0, not 6.

Source files
------------

// File: rtl/eql_irq_peer.sv
// eql_irq_peer: peripheral-side partner of the interrupt-handshake controller.
// Converts a level service request into an eql request/hold/release sequence
// and keeps the saturating event counter reported on cont_eql.
//
// Handshake: eql rises the cycle after req_in is seen in IDLE and stays high
// until the controller acknowledges (cc_mux == 2'b11) or TIMEOUT cycles pass.
// After an acknowledge eql stays high for HOLD_CYC more cycles, then drops.
// The peer then waits, with no time limit, for uscite to leave 2'b00.
// It pulses done, spends one COOL cycle, and returns to IDLE.
module eql_irq_peer #(
  parameter int CNT_W    = 4,
  parameter int CMP_VAL  = 9,
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_in,
  input  logic [1:0]       cc_mux,
  input  logic [1:0]       uscite,
  input  logic             enable_count,
  input  logic             ackout,
  output logic             eql,
  output logic             cont_eql,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ack_seen,
  output logic [2:0]       state_dbg
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int HW = $clog2(HOLD_CYC) + 1;
  localparam logic [TW-1:0]    TMR_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMP       = CNT_W'(CMP_VAL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_COOL    = 3'd4
  } state_t;

  state_t         state;
  logic [TW-1:0]  tmr;
  logic [HW-1:0]  hcnt;

  logic ack_in;
  logic ctl_left_ack;
  logic req_timeout;
  logic enter_cool;
  logic enter_idle;

  assign ack_in       = (cc_mux == 2'b11);
  assign ctl_left_ack = (uscite != 2'b00);
  assign req_timeout  = (state == S_REQ) && !ack_in && (tmr == '0);
  assign enter_cool   = (state == S_RELEASE) && ctl_left_ack;
  assign enter_idle   = req_timeout || (state == S_COOL);

  assign busy      = (state != S_IDLE);
  assign cont_eql  = (count == CMP);
  assign state_dbg = state;

  // Handshake sequencer with registered eql/done/err.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      eql   <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      tmr   <= '0;
      hcnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_in) begin
            state <= S_REQ;
            eql   <= 1'b1;
            tmr   <= TMR_LOAD;
          end
        end
        S_REQ: begin
          // Acknowledge wins over an expiring timeout in the same cycle.
          if (ack_in) begin
            state <= S_HOLD;
            hcnt  <= HOLD_LOAD;
          end else if (tmr == '0) begin
            state <= S_IDLE;
            eql   <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_HOLD: begin
          if (hcnt == '0) begin
            state <= S_RELEASE;
            eql   <= 1'b0;
          end else begin
            hcnt <= hcnt - HW'(1);
          end
        end
        S_RELEASE: begin
          if (ctl_left_ack) begin
            state <= S_COOL;
            done  <= 1'b1;
          end
        end
        S_COOL: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          eql   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating event counter; clearing on handshake completion beats increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enter_cool) begin
      count <= '0;
    end else if (enable_count && (count != CMP)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Sticky record of a controller ack seen during the current handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_seen <= 1'b0;
    end else if (enter_idle) begin
      ack_seen <= 1'b0;
    end else if (ackout && busy) begin
      ack_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eql_irq_peer.sv
// Testbench for eql_irq_peer: directed scenarios plus a randomized run
// checked against a phase-level reference model.
module tb_eql_irq_peer;

  localparam int CNT_W    = 4;
  localparam int CMP_VAL  = 9;
  localparam int HOLD_CYC = 2;
  localparam int TIMEOUT  = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_in = 1'b0;
  logic [1:0]       cc_mux = 2'b01;
  logic [1:0]       uscite = 2'b01;
  logic             enable_count = 1'b0;
  logic             ackout = 1'b0;
  logic             eql;
  logic             cont_eql;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             err;
  logic             ack_seen;
  logic [2:0]       state_dbg;

  int n_chk = 0;
  int n_err = 0;

  eql_irq_peer #(
    .CNT_W(CNT_W), .CMP_VAL(CMP_VAL), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .req_in(req_in), .cc_mux(cc_mux),
    .uscite(uscite), .enable_count(enable_count), .ackout(ackout),
    .eql(eql), .cont_eql(cont_eql), .count(count), .busy(busy),
    .done(done), .err(err), .ack_seen(ack_seen), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Reference model: which phase of the handshake we are in and how long
  // we have been there, plus the counter as a plain saturating integer.
  typedef enum {P_IDLE, P_REQ, P_HOLD, P_REL, P_COOL} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_age   = 0;
  int     m_count = 0;
  bit     m_done  = 0;
  bit     m_err   = 0;
  bit     m_ack   = 0;

  task automatic model_edge();
    phase_t nxt;
    bit     was_busy;
    if (reset) begin
      m_phase = P_IDLE; m_age = 0; m_count = 0;
      m_done = 0; m_err = 0; m_ack = 0;
      return;
    end
    was_busy = (m_phase != P_IDLE);
    nxt = m_phase;
    m_done = 0;
    m_err  = 0;
    case (m_phase)
      P_IDLE: if (req_in) nxt = P_REQ;
      P_REQ: begin
        if (cc_mux == 2'b11) nxt = P_HOLD;
        else if (m_age == TIMEOUT - 1) begin nxt = P_IDLE; m_err = 1; end
      end
      P_HOLD: if (m_age == HOLD_CYC - 1) nxt = P_REL;
      P_REL: if (uscite != 2'b00) begin nxt = P_COOL; m_done = 1; end
      P_COOL: nxt = P_IDLE;
    endcase
    if (nxt == P_COOL && m_phase != P_COOL) m_count = 0;
    else if (enable_count && m_count < CMP_VAL) m_count = m_count + 1;
    if (nxt == P_IDLE) m_ack = 0;
    else if (ackout && was_busy) m_ack = 1;
    m_age = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
  endtask

  function automatic logic [10:0] model_vec();
    logic eq_e, busy_e, ce_e;
    eq_e   = (m_phase == P_REQ) || (m_phase == P_HOLD);
    busy_e = (m_phase != P_IDLE);
    ce_e   = (m_count == CMP_VAL);
    return {eq_e, ce_e, 4'(m_count), busy_e, m_done, m_err, m_ack};
  endfunction

  // Driver: advance one clock, keeping the model in step, settle past the edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive_quiet();
    req_in = 0; cc_mux = 2'b01; uscite = 2'b01; enable_count = 0; ackout = 0; reset = 0;
  endtask

  task automatic wait_idle();
    drive_quiet();
    for (int i = 0; i < 40 && busy; i++) step();
    n_chk++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle busy=%b required=0 after 40 cycles", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1; req_in = 1; cc_mux = 2'b11;
    step(); step();
    drive_quiet();
    n_chk++;
    if ({eql, cont_eql, count, busy, done, err, ack_seen, state_dbg} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_state got eql=%b ce=%b cnt=%0d busy=%b done=%b err=%b ack=%b st=%0d required all 0",
               eql, cont_eql, count, busy, done, err, ack_seen, state_dbg);
    end
  endtask

  task automatic test_normal();
    logic e_eql, e_done, e_busy;
    wait_idle();
    for (int cyc = 0; cyc < 10; cyc++) begin
      req_in = (cyc == 0);
      cc_mux = (cyc == 3) ? 2'b11 : 2'b01;
      uscite = (cyc >= 8) ? 2'b01 : 2'b00;
      step();
      e_eql  = (cyc + 1 >= 1) && (cyc + 1 <= 5);
      e_done = (cyc + 1 == 9);
      e_busy = (cyc + 1 <= 9);
      n_chk++;
      if ({eql, done, busy} !== {e_eql, e_done, e_busy}) begin
        n_err++;
        $display("FAIL normal cycle=%0d eql/done/busy got=%b%b%b required=%b%b%b",
                 cyc + 1, eql, done, busy, e_eql, e_done, e_busy);
      end
    end
  endtask

  task automatic test_timeout();
    int hi = 0, errs = 0;
    logic e_eql, e_err, e_busy;
    wait_idle();
    for (int cyc = 0; cyc < 12; cyc++) begin
      req_in = (cyc == 0);
      cc_mux = 2'b01;
      step();
      e_eql  = (cyc + 1 <= 8);
      e_err  = (cyc + 1 == 9);
      e_busy = (cyc + 1 <= 8);
      if (eql) hi++;
      if (err) errs++;
      n_chk++;
      if ({eql, err, busy} !== {e_eql, e_err, e_busy}) begin
        n_err++;
        $display("FAIL timeout cycle=%0d eql/err/busy got=%b%b%b required=%b%b%b",
                 cyc + 1, eql, err, busy, e_eql, e_err, e_busy);
      end
    end
    n_chk++;
    if (hi != TIMEOUT || errs != 1) begin
      n_err++;
      $display("FAIL timeout_totals eql_high=%0d err_pulses=%0d required %0d and 1", hi, errs, TIMEOUT);
    end
  endtask

  task automatic test_ack_timeout();
    logic e_eql, e_done;
    wait_idle();
    for (int cyc = 0; cyc < 13; cyc++) begin
      req_in = (cyc == 0);
      cc_mux = (cyc == 8) ? 2'b11 : 2'b01;
      uscite = (cyc >= 11) ? 2'b01 : 2'b00;
      step();
      e_eql  = (cyc + 1 <= 10);
      e_done = (cyc + 1 == 12);
      n_chk++;
      if ({eql, err, done} !== {e_eql, 1'b0, e_done}) begin
        n_err++;
        $display("FAIL ack_vs_timeout cycle=%0d eql/err/done got=%b%b%b required=%b0%b",
                 cyc + 1, eql, err, done, e_eql, e_done);
      end
    end
  endtask

  task automatic test_saturation();
    int start, e_cnt;
    wait_idle();
    start = m_count;
    enable_count = 1;
    for (int k = 1; k <= 15; k++) begin
      step();
      e_cnt = (start + k > CMP_VAL) ? CMP_VAL : start + k;
      n_chk++;
      if (count !== 4'(e_cnt) || cont_eql !== (e_cnt == CMP_VAL)) begin
        n_err++;
        $display("FAIL saturation step=%0d count=%0d ce=%b required count=%0d ce=%b",
                 k, count, cont_eql, e_cnt, (e_cnt == CMP_VAL));
      end
    end
    enable_count = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      req_in = (cyc == 0);
      cc_mux = (cyc == 1) ? 2'b11 : 2'b01;
      uscite = 2'b01;
      step();
      if (cyc == 4) begin
        n_chk++;
        if ({done, cont_eql, count} !== {1'b1, 1'b0, 4'd0}) begin
          n_err++;
          $display("FAIL sat_clear done=%b ce=%b count=%0d required done=1 ce=0 count=0",
                   done, cont_eql, count);
        end
      end
    end
  endtask

  task automatic test_clear_vs_inc();
    wait_idle();
    enable_count = 1;
    for (int k = 0; k < 5; k++) step();
    enable_count = 0;
    n_chk++;
    if (count !== 4'd5) begin
      n_err++;
      $display("FAIL clr_setup count=%0d required 5", count);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      req_in       = (cyc == 0);
      cc_mux       = (cyc == 1) ? 2'b11 : 2'b01;
      uscite       = (cyc == 4) ? 2'b01 : 2'b00;
      enable_count = (cyc == 4);
      step();
      if (cyc == 3) begin
        n_chk++;
        if ({eql, busy, count} !== {1'b0, 1'b1, 4'd5}) begin
          n_err++;
          $display("FAIL clr_release eql=%b busy=%b count=%0d required 0 1 5", eql, busy, count);
        end
      end
      if (cyc == 4) begin
        n_chk++;
        if ({done, count} !== {1'b1, 4'd0}) begin
          n_err++;
          $display("FAIL clr_vs_inc done=%b count=%0d required done=1 count=0", done, count);
        end
      end
    end
    enable_count = 0;
  endtask

  task automatic test_reset_mid_hold();
    wait_idle();
    for (int cyc = 0; cyc < 5; cyc++) begin
      req_in       = (cyc == 0);
      cc_mux       = (cyc == 1) ? 2'b11 : 2'b01;
      uscite       = 2'b00;
      ackout       = (cyc == 1);
      enable_count = (cyc <= 2);
      reset        = (cyc == 2);
      step();
      if (cyc >= 2) begin
        n_chk++;
        if ({eql, busy, state_dbg, done, err, ack_seen} !== 8'd0 ||
            (cyc == 2 && count !== 4'd0)) begin
          n_err++;
          $display("FAIL reset_mid_hold cycle=%0d eql=%b busy=%b st=%0d count=%0d ack=%b required idle zeros",
                   cyc + 1, eql, busy, state_dbg, count, ack_seen);
        end
      end
    end
    drive_quiet();
  endtask

  task automatic test_back_to_back();
    int low_run = 0, rises = 0;
    logic [10:0] exp_v;
    wait_idle();
    req_in = 1; cc_mux = 2'b11; uscite = 2'b01; low_run = 2;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      exp_v = model_vec();
      n_chk++;
      if ({eql, cont_eql, count, busy, done, err, ack_seen} !== exp_v) begin
        n_err++;
        $display("FAIL b2b cycle=%0d got=%h required=%h", cyc, {eql, cont_eql, count, busy, done, err, ack_seen}, exp_v);
      end
      if (eql) begin
        if (low_run > 0) begin
          rises++;
          n_chk++;
          if (low_run < 2) begin
            n_err++;
            $display("FAIL b2b_gap eql low for %0d cycles required >=2", low_run);
          end
        end
        low_run = 0;
      end else low_run++;
    end
    n_chk++;
    if (rises < 3) begin
      n_err++;
      $display("FAIL b2b_count handshakes=%0d required >=3", rises);
    end
    drive_quiet();
  endtask

  task automatic test_random();
    logic [10:0] exp_v;
    wait_idle();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset        = ($urandom_range(0, 199) == 0);
      req_in       = ($urandom_range(0, 3) == 0);
      cc_mux       = 2'($urandom_range(0, 3));
      uscite       = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      enable_count = $urandom_range(0, 1);
      ackout       = $urandom_range(0, 1);
      step();
      exp_v = model_vec();
      n_chk++;
      if ({eql, cont_eql, count, busy, done, err, ack_seen} !== exp_v) begin
        n_err++;
        $display("FAIL random cycle=%0d {eql,ce,cnt,busy,done,err,ack} got=%h required=%h",
                 cyc, {eql, cont_eql, count, busy, done, err, ack_seen}, exp_v);
      end
    end
    drive_quiet();
  endtask

  // Sequence of scenarios and final report.
  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_ack_timeout();
    test_saturation();
    test_clear_vs_inc();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
